// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with architectural HI/LO, fixed per-op latency and cancel.
// The result is computed at accept and held pending; the countdown only models pipeline occupancy.
module mdu_unit #(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int MAXL = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;

   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, phi_q, phi_d, plo_q, plo_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               busy_q, busy_d, done_q, done_d;
   logic [2*WIDTH-1:0] ma, mb, prod;
   logic [WIDTH-1:0]   ua, ub, dv, q, r, qf, rf;
   logic               na, nb, accept;

   // Sign-extending into 2*WIDTH lets one multiplier serve both mult and multu.
   assign ma   = {{WIDTH{~op[0] & a[WIDTH-1]}}, a};
   assign mb   = {{WIDTH{~op[0] & b[WIDTH-1]}}, b};
   assign prod = ma * mb;

   // Signed divide via magnitudes; MIN / -1 wraps back to MIN with remainder 0.
   assign na = ~op[0] & a[WIDTH-1];
   assign nb = ~op[0] & b[WIDTH-1];
   assign ua = na ? -a : a;
   assign ub = nb ? -b : b;
   assign dv = (ub == '0) ? WIDTH'(1) : ub;
   assign q  = ua / dv;
   assign r  = ua % dv;
   assign qf = (na ^ nb) ? -q : q;
   assign rf = na ? -r : r;

   assign accept = start & ~busy_q & ~cancel;

   always_comb begin
      hi_d   = hi_q;
      lo_d   = lo_q;
      phi_d  = phi_q;
      plo_d  = plo_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = 1'b0;
      if (busy_q) begin
         if (cancel) begin
            busy_d = 1'b0;
            cnt_d  = '0;
         end else if (cnt_q == '0) begin
            hi_d   = phi_q;
            lo_d   = plo_q;
            busy_d = 1'b0;
            done_d = 1'b1;
         end else begin
            cnt_d = cnt_q - CW'(1);
         end
      end else if (accept) begin
         case (op)
            3'd0, 3'd1: begin
               phi_d  = prod[2*WIDTH-1:WIDTH];
               plo_d  = prod[WIDTH-1:0];
               cnt_d  = CW'(MUL_LAT - 1);
               busy_d = 1'b1;
            end
            3'd2, 3'd3: begin
               phi_d  = (b == '0) ? a : rf;
               plo_d  = (b == '0) ? '1 : qf;
               cnt_d  = CW'(DIV_LAT - 1);
               busy_d = 1'b1;
            end
            3'd4:    hi_d = a;
            3'd5:    lo_d = a;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q   <= '0;
         lo_q   <= '0;
         phi_q  <= '0;
         plo_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         phi_q  <= phi_d;
         plo_q  <= plo_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed vectors; expected {hi,lo} queued at issue, checked by a done-driven monitor.
module tb_mdu_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd7;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        cancel = 1'b0;
   logic        busy, done;
   logic [31:0] hi, lo;
   logic [63:0] sb[$];
   int          checks = 0;
   int          errors = 0;

   mdu_unit #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Issue one request; returns at the falling edge after the accepting rising edge.
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int exp);
      int n = 0;
      while (busy && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk(name, n, exp);
   endtask

   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 hi=0x%08h lo=0x%08h expected none", hi, lo);
         end else begin
            logic [63:0] e;
            e = sb.pop_front();
            chk("commit_hi", hi, e[63:32]);
            chk("commit_lo", lo, e[31:0]);
         end
      end
   end

   initial begin
      #1;
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      issue(3'd4, 32'h12345678, 32'h0);
      chk("mthi_busy", 32'(busy), 32'h0);
      issue(3'd5, 32'h9ABCDEF0, 32'h0);
      chk("mtlo_busy", 32'(busy), 32'h0);
      chk("mtlo_done", 32'(done), 32'h0);
      chk("mthi_hi", hi, 32'h12345678);
      chk("mtlo_lo", lo, 32'h9ABCDEF0);

      sb.push_back({32'hFFFFFFFF, 32'hFFFFFFFE});
      issue(3'd0, 32'hFFFFFFFF, 32'h2);
      wait_idle("mult_busy_cycles", 5);
      sb.push_back({32'h00000001, 32'hFFFFFFFE});
      issue(3'd1, 32'hFFFFFFFF, 32'h2);
      wait_idle("multu_busy_cycles", 5);

      sb.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
      issue(3'd2, 32'hFFFFFFF9, 32'h2);
      wait_idle("div_busy_cycles", 10);
      sb.push_back({32'h00000007, 32'hFFFFFFFF});
      issue(3'd3, 32'h7, 32'h0);
      wait_idle("divu0_busy_cycles", 10);
      sb.push_back({32'h00000000, 32'h80000000});
      issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
      wait_idle("divmin_busy_cycles", 10);

      // Busy hold: hi/lo stay at 0x11 and a mid-busy multu is dropped.
      issue(3'd4, 32'h11, 32'h0);
      issue(3'd5, 32'h11, 32'h0);
      sb.push_back({32'd2, 32'd14});
      issue(3'd2, 32'd100, 32'd7);
      begin
         int n = 0;
         while (busy && n < 50) begin
            chk("hold_hi", hi, 32'h11);
            chk("hold_lo", lo, 32'h11);
            start = (n == 3);
            op = 3'd1; a = 32'd5; b = 32'd5;
            n++;
            @(negedge clk);
         end
         start = 1'b0;
         chk("hold_busy_cycles", n, 10);
      end
      repeat (2) @(negedge clk);
      chk("ignored_start_busy", 32'(busy), 32'h0);

      issue(3'd0, 32'd3, 32'd4);
      repeat (2) @(negedge clk);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      chk("cancel_busy", 32'(busy), 32'h0);
      chk("cancel_hi", hi, 32'd2);
      chk("cancel_lo", lo, 32'd14);
      repeat (7) @(negedge clk);

      issue(3'd1, 32'd6, 32'd7);
      repeat (4) @(negedge clk);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      chk("cancel_commit_busy", 32'(busy), 32'h0);
      chk("cancel_commit_hi", hi, 32'd2);
      chk("cancel_commit_lo", lo, 32'd14);
      repeat (3) @(negedge clk);

      @(negedge clk);
      cancel = 1'b1; start = 1'b1; op = 3'd4; a = 32'hDEAD;
      @(negedge clk);
      cancel = 1'b0; start = 1'b0;
      chk("cancel_blocks_mthi", hi, 32'd2);

      issue(3'd6, 32'hAAAA, 32'hBBBB);
      chk("illegal_busy", 32'(busy), 32'h0);
      chk("illegal_hi", hi, 32'd2);
      chk("illegal_lo", lo, 32'd14);

      issue(3'd2, 32'd9, 32'd3);
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("rstmid_busy", 32'(busy), 32'h0);
      chk("rstmid_hi", hi, 32'h0);
      chk("rstmid_lo", lo, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("rstmid_idle", 32'(busy), 32'h0);

      sb.push_back({32'd0, 32'd6});
      issue(3'd1, 32'd2, 32'd3);
      wait_idle("b2b_multu_cycles", 5);
      chk("b2b_done", 32'(done), 32'h1);
      chk("b2b_mflo", lo, 32'd6);
      sb.push_back({32'd2, 32'd3});
      start = 1'b1; op = 3'd3; a = 32'd20; b = 32'd6;
      @(negedge clk);
      start = 1'b0;
      chk("b2b_accept_busy", 32'(busy), 32'h1);
      wait_idle("b2b_divu_cycles", 10);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Parametrised multi-cycle multiply/divide unit; the next-generation companion to the single-cycle combinational ALU in the EX stage of the pipelined MIPS core.
- Executes mult/multu/div/divu into architectural HI/LO registers with configurable latency, plus mthi/mtlo writes.
- Exposes busy/done so the hazard unit stalls mfhi/mflo and further MDU ops while an operation is in flight.
- Supports cancel, used for exception flushes.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be at least 2.
- MUL_LAT, 5, cycles busy for mult/multu; must be at least 1.
- DIV_LAT, 10, cycles busy for div/divu; must be at least 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled at the rising edge
- op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6 and 7 are no-op
- a  input  WIDTH  rs operand
- b  input  WIDTH  rt operand
- cancel  input  1  abort the in-flight op (exception flush)
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse when HI/LO are committed by mul/div
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - rst_n=0 forces hi=0, lo=0, busy=0, done=0, internal counter=0, pending result=0, immediately, without waiting for a clock edge.
  - A reset during an operation discards it with no HI/LO commit.
- Accept rule: start=1 and busy=0 and cancel=0 at the edge accepts op. Start while busy=1 is ignored; the bench must never rely on queueing.
- mthi/mtlo:
  - On accept, hi<=a (mthi) or lo<=a (mtlo) at that same edge.
  - busy stays 0 and done stays 0.
- mul/div on accept:
  - Latch the full result into a pending hi/lo.
  - Load the counter with LAT-1.
  - busy=1 from that edge.
- Countdown:
  - While busy, the counter decrements each edge.
  - At the edge where the counter is 0: hi<=pending hi, lo<=pending lo, busy<=0, done<=1.
  - busy is therefore high for exactly LAT cycles.
  - done is high for the single cycle after the commit.
- HI/LO visibility: hi/lo keep their old values throughout busy. Stalling readers is the hazard unit's job.
- Back-to-back ops: a new start may be accepted in the cycle after busy falls, i.e. while done=1.
- cancel:
  - busy=1 and cancel=1 at an edge gives busy<=0 and counter<=0.
  - HI/LO are unchanged and done stays 0.
  - cancel=1 with busy=0 blocks any start in that cycle, including mthi/mtlo.
  - If cancel arrives in the commit cycle (counter=0), cancel wins and there is no commit.
- Arithmetic:
  - mult: signed WIDTH×WIDTH gives a 2·WIDTH product; hi = upper half, lo = lower half.
  - multu: the same, unsigned.
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend (a).
  - divu: unsigned quotient and remainder.
- Divide boundary cases:
  - b=0 (div or divu): lo = all ones, hi = a. The timing is still the full DIV_LAT.
  - div with a = most negative value and b = -1: lo = most negative value, hi = 0.
- Illegal op: op 6/7 with start is accepted as a no-op; busy, hi, lo and done are unchanged.
- No overflow output: mul/div never trap.

Test Plan:
- Reset then mthi/mtlo, with rst_n low then released and defaults: hi=lo=0. Then start op=4 a=0x12345678, next start op=5 a=0x9ABCDEF0 → hi=0x12345678, lo=0x9ABCDEF0, busy never asserted.
- Signed vs unsigned multiply with a=0xFFFFFFFF, b=0x00000002:
  - mult → hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - multu → hi=0x00000001, lo=0xFFFFFFFE.
  - Each gives busy for exactly 5 cycles, then a 1-cycle done.
- Division with a=-7 (0xFFFFFFF9), b=2:
  - div → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - divu a=7 b=0 → lo=0xFFFFFFFF, hi=7.
  - div a=0x80000000 b=0xFFFFFFFF → lo=0x80000000, hi=0.
  - Each gives busy for 10 cycles.
- Busy-hold and ignored start:
  - During div with hi=lo=0x11, hi/lo read 0x11 every busy cycle.
  - A start multu issued mid-busy is ignored; the final result is only the div result.
- Cancel and reset mid-op:
  - mult 3×4 cancelled in its 3rd busy cycle → busy low next edge, hi/lo unchanged, no done.
  - cancel in the commit cycle → no commit.
  - rst_n pulsed low mid-div → busy=0 and hi=lo=0 asynchronously, no done.
- Back-to-back:
  - multu 2×3 committed, then mflo-equivalent check lo=6.
  - A new start in the done cycle is accepted, giving busy again on the next cycle.
